// File: rtl/datapath_pkg.sv
// datapath_pkg
//   Constants shared by the integer datapath blocks.
//   XLEN       : architectural register width in bits
//   REG_ADDR_W : width of a register index
//   NUM_REGS   : number of integer registers
//   ZERO_REG   : index of the hardwired-zero register
package datapath_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
//   One combinational read port of the integer register file: a 2**ADDR_W:1
//   mux over the flattened register storage. Index 0 is forced to zero so the
//   port never depends on whatever the storage holds for x0.
// Ports:
//   regs_i : all registers, packed, register n in regs_i[n]
//   idx_i  : register index to read
//   data_o : contents of register idx_i (0 when idx_i is 0)
module regfile_read_port
  import datapath_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]                  idx_i,
  output logic [DATA_W-1:0]                  data_o
);

  assign data_o = (idx_i == ADDR_W'(ZERO_REG)) ? '0 : regs_i[idx_i];

endmodule

// File: rtl/register_file.sv
// register_file
//   32 x 32-bit integer register file with two combinational read ports and
//   one synchronous write port. x0 reads as zero and ignores writes. Storage
//   is plain flip-flops with asynchronous clear; there is no write-to-read
//   bypass, so a read of the register being written shows the old value until
//   the capturing edge.
// Ports:
//   clk        : clock, write port updates on its rising edge
//   rst_n      : asynchronous active-low reset, clears every register
//   rs1, rs2   : read port indices
//   rd         : write port index
//   write_data : value written to register rd
//   reg_write  : write enable, active high
//   read_data1 : contents of register rs1
//   read_data2 : contents of register rs2
module register_file
  import datapath_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;

  // Entry 0 is pinned to zero here as well as in the read ports, so the
  // flops behind it are constant and get trimmed by synthesis.
  always_comb begin
    regs_d = regs_q;
    if (reg_write && (rd != ADDR_W'(ZERO_REG))) begin
      regs_d[rd] = write_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port1 (
    .regs_i (regs_q),
    .idx_i  (rs1),
    .data_o (read_data1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port2 (
    .regs_i (regs_q),
    .idx_i  (rs2),
    .data_o (read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Self-checking bench for register_file: directed cases for reset, both
//   ports, x0, write enable, same-cycle read/write and mid-cycle reset, then
//   randomized traffic checked against an array model of the 32 registers.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] write_data = '0;
  logic        reg_write = 1'b0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  register_file #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  // Reference: plain array of register values; entry 0 is never written.
  logic [31:0] model [32];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : model[idx];
  endfunction

  // One transaction, entered just after a falling edge: drive, check the
  // pre-edge (old) values, take the rising edge, update the model, check the
  // post-edge values, then move to the next falling edge.
  task automatic cycle(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    reg_write = we; rd = wa; write_data = wd; rs1 = a1; rs2 = a2;
    #1;
    check({tag, " pre rd1"}, read_data1, ref_read(a1));
    check({tag, " pre rd2"}, read_data2, ref_read(a2));
    @(posedge clk);
    if (we && wa != 5'd0 && rst_n) model[wa] = wd;
    #1;
    check({tag, " post rd1"}, read_data1, ref_read(a1));
    check({tag, " post rd2"}, read_data2, ref_read(a2));
    $display("txn %s we=%0d rd=%0d wd=%h rs1=%0d->%h rs2=%0d->%h",
             tag, we, wa, wd, a1, read_data1, a2, read_data2);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    // Reset held: every index reads 0, and enabled writes go nowhere.
    reg_write = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i); rd = 5'(i); write_data = $urandom;
      #2;
      check("reset sweep rd1", read_data1, 32'd0);
      check("reset sweep rd2", read_data2, 32'd0);
    end
    $display("txn reset sweep done");
    reg_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Port 1 and port 2 directed writes.
    cycle("wr x1", 1'b1, 5'd1, 32'hDEADBEEF, 5'd1, 5'd0);
    cycle("rd x1", 1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
    check("port1 x1", read_data1, 32'hDEADBEEF);
    cycle("wr x2", 1'b1, 5'd2, 32'hCAFEBABE, 5'd1, 5'd2);
    cycle("rd x2", 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
    check("port2 x2", read_data2, 32'hCAFEBABE);
    check("port1 x1 kept", read_data1, 32'hDEADBEEF);

    // x0 ignores writes; disabled write leaves x3 alone.
    cycle("wr x0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("x0 zero", read_data1, 32'd0);
    cycle("we=0 x3", 1'b0, 5'd3, 32'h12345678, 5'd0, 5'd3);
    check("we0 x3", read_data2, 32'd0);

    // Same-cycle read/write of x4: old value before the edge, new after.
    reg_write = 1'b1; rd = 5'd4; write_data = 32'hA5A5A5A5; rs1 = 5'd4; rs2 = 5'd4;
    #1;
    check("rw x4 before", read_data1, 32'd0);
    @(posedge clk);
    model[4] = 32'hA5A5A5A5;
    #1;
    check("rw x4 after", read_data1, 32'hA5A5A5A5);
    check("rw x4 after p2", read_data2, 32'hA5A5A5A5);
    $display("txn same-cycle x4 -> %h", read_data1);
    @(negedge clk);

    // Randomized traffic; rd=0, we=0 and rs1=rs2 arise naturally.
    for (int n = 0; n < 300; n++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
    end

    // Fill x1..x31 with unique values and confirm them.
    for (int i = 1; i < 32; i++) begin
      cycle("fill", 1'b1, 5'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 5'(i), 5'(32 - i));
    end

    // Reset asserted between edges with a write pending.
    reg_write = 1'b1; rd = 5'd7; write_data = 32'h7777_7777;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      check("midrst rd1", read_data1, 32'd0);
      check("midrst rd2", read_data2, 32'd0);
    end
    @(posedge clk);
    #1;
    rs1 = 5'd7; rs2 = 5'd31;
    #1;
    check("midrst blocked x7", read_data1, 32'd0);
    check("midrst x31", read_data2, 32'd0);
    $display("txn mid-cycle reset done");
    reg_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release accepts a write.
    cycle("post-rst wr", 1'b1, 5'd9, 32'h0BAD_F00D, 5'd9, 5'd7);
    check("post-rst x9", read_data1, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
